// File: rtl/dual_lane_deser.sv
// -----------------------------------------------------------------------------
// dual_lane_deser
//
// Two-lane bit-serial receiver. Each lane collects DW serial bits, LSB first,
// into a private shift register. A finished word goes to an output register
// that has a valid/ready handshake. The transmitter sends the complement of
// each word, so the receiver stores each bit inverted and restores the
// original value.
//
// Build option:
//   DESER_INVERT_EN  defined   -> each received bit is complemented before
//                                 storage (normal link mode).
//                    undefined -> bits are stored unmodified (raw
//                                 deserializer). Handshake and timing are
//                                 identical in both modes.
//
// Ports (x = 0 / 1):
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   inx_valid    in   serial bit present on lane x
//   inx          in   serial data bit for lane x
//   inx_ready    out  lane x accepts a bit this cycle (registered state only)
//   outx_valid   out  assembled word available on lane x
//   outx         out  assembled word for lane x (DW bits)
//   outx_ready   in   consumer accepts the word on lane x
//
// The two lanes are separate instances of dual_lane_deser_lane and share no
// state. A stall on one lane therefore cannot affect the other.
// -----------------------------------------------------------------------------

// One receive lane: bit counter, shift register, output register and a
// two-state flow-control FSM.
module dual_lane_deser_lane #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic          in_bit,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready
);

   localparam int CW = (DW > 1) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

   // COLLECT: shifting bits in. HOLD: sh_q holds a complete word that
   // waits for the output register to free up.
   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_HOLD    = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] sh_q, sh_d;
   logic [DW-1:0] out_q, out_d;
   logic          out_valid_q, out_valid_d;
   logic          accept_s;
   logic          pop_s;

   // Polarity applied to each received bit before it is stored.
   function automatic logic store_bit(input logic b);
`ifdef DESER_INVERT_EN
      return ~b;
`else
      return b;
`endif
   endfunction

   // The ready signal comes only from the registered state, so it never
   // depends combinationally on out_ready.
   assign in_ready  = (state_q == ST_COLLECT);
   assign out_valid = out_valid_q;
   assign out_data  = out_q;

   assign accept_s = in_valid && (state_q == ST_COLLECT);
   assign pop_s    = out_valid_q && out_ready;

   // Next-state logic: bit capture, word completion and output handshake.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh_d        = sh_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;

      // A pop empties the output unless a new word refills it below.
      if (pop_s) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end

      case (state_q)
         ST_COLLECT: begin
            if (accept_s) begin
               sh_d[cnt_q] = store_bit(in_bit);
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  // The output register is free when it is empty, or when it
                  // is popped on this same edge (replacement with no bubble).
                  if (!out_valid_q || out_ready) begin
                     out_d       = sh_d;
                     out_valid_d = 1'b1;
                  end else begin
                     state_d = ST_HOLD;
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_HOLD: begin
            // Here out_valid_q is 1, so a pop is just out_ready.
            if (pop_s) begin
               out_d       = sh_q;
               out_valid_d = 1'b1;
               state_d     = ST_COLLECT;
            end else begin
               state_d = ST_HOLD;
            end
         end
         default: begin
            state_d = ST_COLLECT;
         end
      endcase
   end

   // State register with asynchronous reset. A reset drops any partial or
   // held word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_COLLECT;
         cnt_q       <= '0;
         sh_q        <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// Top level: two independent lanes.
module dual_lane_deser #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in0_valid,
   input  logic          in0,
   output logic          in0_ready,
   output logic          out0_valid,
   output logic [DW-1:0] out0,
   input  logic          out0_ready,
   input  logic          in1_valid,
   input  logic          in1,
   output logic          in1_ready,
   output logic          out1_valid,
   output logic [DW-1:0] out1,
   input  logic          out1_ready
);

   dual_lane_deser_lane #(.DW(DW)) u_lane0 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in0_valid),
      .in_bit    (in0),
      .in_ready  (in0_ready),
      .out_valid (out0_valid),
      .out_data  (out0),
      .out_ready (out0_ready)
   );

   dual_lane_deser_lane #(.DW(DW)) u_lane1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in1_valid),
      .in_bit    (in1),
      .in_ready  (in1_ready),
      .out_valid (out1_valid),
      .out_data  (out1),
      .out_ready (out1_ready)
   );

endmodule

// File: tb/tb_dual_lane_deser.sv
// -----------------------------------------------------------------------------
// tb_dual_lane_deser
//
// Checks dual_lane_deser (DW = 8) against a reference model. For each lane the
// model keeps a queue of the bits received so far and a queue of the finished
// words that have not yet been consumed:
//   - in_ready  is expected high while fewer than two words are pending;
//   - out_valid is expected high while at least one word is pending;
//   - out       is expected to equal the oldest pending word.
// The model follows DESER_INVERT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_dual_lane_deser;

   localparam int DW = 8;

   logic          clk;
   logic          rst_n;
   logic [1:0]    iv;
   logic [1:0]    id;
   logic [1:0]    ordy;
   logic [1:0]    ir;
   logic [1:0]    ov;
   logic [DW-1:0] od0;
   logic [DW-1:0] od1;

   int n_cmp;
   int n_bad;

   bit            b0[$];
   bit            b1[$];
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];

   dual_lane_deser #(.DW(DW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in0_valid  (iv[0]),
      .in0        (id[0]),
      .in0_ready  (ir[0]),
      .out0_valid (ov[0]),
      .out0       (od0),
      .out0_ready (ordy[0]),
      .in1_valid  (iv[1]),
      .in1        (id[1]),
      .in1_ready  (ir[1]),
      .out1_valid (ov[1]),
      .out1       (od1),
      .out1_ready (ordy[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Value the design must present for a word that was sent on the wire.
   function automatic logic [DW-1:0] xf(input logic [DW-1:0] w);
`ifdef DESER_INVERT_EN
      return ~w;
`else
      return w;
`endif
   endfunction

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks the current outputs against the model, records this cycle's
   // handshakes in the model, then advances one clock (to 1 time unit after
   // the edge).
   task automatic tick();
      logic [DW-1:0] w;
      chk_b("rdy0", ir[0], q0.size() < 2);
      chk_b("vld0", ov[0], q0.size() > 0);
      if (q0.size() > 0) chk_w("dat0", od0, q0[0]);
      chk_b("rdy1", ir[1], q1.size() < 2);
      chk_b("vld1", ov[1], q1.size() > 0);
      if (q1.size() > 0) chk_w("dat1", od1, q1[0]);

      if (ov[0] && ordy[0] && q0.size() > 0) void'(q0.pop_front());
      if (iv[0] && ir[0]) begin
         b0.push_back(id[0]);
         if (b0.size() == DW) begin
            for (int i = 0; i < DW; i++) w[i] = b0[i];
            b0.delete();
            q0.push_back(xf(w));
         end
      end
      if (ov[1] && ordy[1] && q1.size() > 0) void'(q1.pop_front());
      if (iv[1] && ir[1]) begin
         b1.push_back(id[1]);
         if (b1.size() == DW) begin
            for (int i = 0; i < DW; i++) w[i] = b1[i];
            b1.delete();
            q1.push_back(xf(w));
         end
      end
      @(posedge clk);
      #1;
   endtask

   // Sends one word LSB first on lane l. If gapped is set, valid drops for
   // one cycle after each bit.
   task automatic send(input int l, input logic [DW-1:0] w, input bit gapped);
      for (int i = 0; i < DW; i++) begin
         iv[l] = 1'b1;
         id[l] = w[i];
         tick();
         if (gapped) begin
            iv[l] = 1'b0;
            tick();
         end
      end
      iv[l] = 1'b0;
   endtask

   task automatic model_reset();
      b0.delete();
      b1.delete();
      q0.delete();
      q1.delete();
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      iv    = 2'b00;
      id    = 2'b00;
      ordy  = 2'b11;
      #12;
      chk_b("rst_vld0", ov[0], 1'b0);
      chk_b("rst_vld1", ov[1], 1'b0);
      chk_w("rst_out0", od0, 8'h00);
      chk_w("rst_out1", od1, 8'h00);
      chk_b("rst_rdy0", ir[0], 1'b1);
      chk_b("rst_rdy1", ir[1], 1'b1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single word: the output is valid for exactly one cycle after the last bit.
      send(0, 8'hA5, 1'b0);
      chk_w("single_out0", od0, xf(8'hA5));
      chk_b("single_vld0", ov[0], 1'b1);
      tick();
      chk_b("single_vld0_gone", ov[0], 1'b0);

      // Reset in the middle of a word on both lanes.
      iv = 2'b11;
      for (int i = 0; i < 3; i++) begin
         id = 2'($urandom);
         tick();
      end
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk_b("mid_rst_vld0", ov[0], 1'b0);
      chk_b("mid_rst_vld1", ov[1], 1'b0);
      chk_w("mid_rst_out0", od0, 8'h00);
      chk_w("mid_rst_out1", od1, 8'h00);
      chk_b("mid_rst_rdy0", ir[0], 1'b1);
      chk_b("mid_rst_rdy1", ir[1], 1'b1);
      iv = 2'b00;
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(1, 8'h3A, 1'b0);
      chk_w("fresh_out1", od1, xf(8'h3A));
      send(0, 8'hC6, 1'b0);
      chk_w("fresh_out0", od0, xf(8'hC6));
      tick();

      // Backpressure on lane 0.
      ordy[0] = 1'b0;
      send(0, 8'h0F, 1'b0);
      chk_w("bp_first", od0, xf(8'h0F));
      send(0, 8'hF0, 1'b0);
      chk_b("bp_hold_rdy", ir[0], 1'b0);
      chk_w("bp_hold_out", od0, xf(8'h0F));
      ordy[0] = 1'b1;
      tick();
      ordy[0] = 1'b0;
      chk_w("bp_release_out", od0, xf(8'hF0));
      chk_b("bp_release_rdy", ir[0], 1'b1);
      chk_b("bp_release_vld", ov[0], 1'b1);

      // Lane independence: lane 1 stays in HOLD while lane 0 streams.
      ordy[1] = 1'b0;
      send(1, 8'h11, 1'b0);
      send(1, 8'h22, 1'b0);
      chk_b("ind_hold_rdy1", ir[1], 1'b0);
      ordy[0] = 1'b1;
      send(0, 8'h00, 1'b0);
      chk_w("ind_w0", od0, xf(8'h00));
      send(0, 8'hFF, 1'b0);
      chk_w("ind_w1", od0, xf(8'hFF));
      send(0, 8'h3C, 1'b0);
      chk_w("ind_w2", od0, xf(8'h3C));
      chk_w("ind_lane1_out", od1, xf(8'h11));
      chk_b("ind_lane1_rdy", ir[1], 1'b0);

      // Drain lane 1, then send a word with valid toggling every cycle.
      ordy[1] = 1'b1;
      tick();
      tick();
      chk_b("drain_vld1", ov[1], 1'b0);
      ordy[1] = 1'b0;
      send(1, 8'h81, 1'b1);
      chk_w("gap_out1", od1, xf(8'h81));
      chk_b("gap_vld1", ov[1], 1'b1);
      ordy[1] = 1'b1;
      tick();

      // Random traffic on both lanes.
      for (int c = 0; c < 3000; c++) begin
         iv   = 2'($urandom);
         id   = 2'($urandom);
         ordy = 2'($urandom);
         tick();
      end
      iv   = 2'b00;
      ordy = 2'b11;
      for (int c = 0; c < 4; c++) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
